mips_exec_mem_unit: RTL and testbench
=====================================

Name: mips_exec_mem_unit

Overview:
Execute-plus-memory datapath slice of the single-cycle MIPS core. It contains three parts:
- ALU-control decoder: maps the main-control aluop and the instruction funct field to a 4-bit ALU operation and a jr flag.
- 32-bit ALU: computes the result and zero flag.
- Word-organised data memory: addressed by the ALU result.
It sits between the register file / ALUSrc mux and the memtoreg write-back mux. The zero flag feeds branch logic, and jump_reg feeds the PC-source mux and the register-write gating.

Parameters:
DATA_W, 32, datapath width (fixed at 32; shifts use shamt[4:0]).
DMEM_DEPTH, 256, data-memory depth in 32-bit words (power of two).
DMEM_AW, log2(DMEM_DEPTH), word-index width.

Ports:
clk  in  1  rising-edge clock for memory writes.
reset  in  1  asynchronous, active-low; clears data memory.
aluop  in  2  from control unit: {aluop1, aluop0}.
funct  in  6  instruction[5:0].
shamt  in  5  instruction[10:6].
op_a  in  32  register read_data1.
op_b  in  32  ALUSrc mux output (read_data2 or sign-extended immediate).
store_data  in  32  register read_data2.
memread  in  1  enables read_data.
memwrite  in  1  write enable.
alu_ctrl  out  4  decoded ALU operation.
jump_reg  out  1  high for jr.
alu_result  out  32  ALU result, also the memory byte address.
zero  out  1  high when alu_result == 0.
read_data  out  32  memory read data.

Behaviour:
- ALU control is combinational. The codes are: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SUB 0110, SLT 0111, NOR 1100.
- Decode by aluop:
  - 00: ADD (lw/sw address).
  - 01: SUB (beq).
  - 11: OR (ori).
  - 10: decode funct.
- R-type funct decode (aluop = 10):
  - 100000 ADD; 100010 SUB; 100100 AND; 100101 OR; 100111 NOR; 101010 SLT.
  - 000000 SLL; 000010 SRL.
  - 001000 jr: ADD, with jump_reg = 1.
  - Any other funct: ADD, with jump_reg = 0.
- jump_reg is 1 only when aluop = 10 and funct = 001000.
- ALU is combinational:
  - ADD and SUB are modulo 2^32; carry and overflow are discarded.
  - SLT is a signed compare and yields 32'd1 or 32'd0.
  - SLL and SRL shift op_b by shamt; SRL is a logical shift (zero fill).
  - zero = (alu_result == 0).
- Memory word index = alu_result[DMEM_AW+1:2]. Bits [1:0] are ignored (no misalignment trap). Upper bits are ignored, so addresses wrap modulo DMEM_DEPTH*4.
- Write: on rising clk, when memwrite = 1 and reset = 1, mem[index] <= store_data.
- Read: combinational. read_data = mem[index] when memread = 1, else 32'h0.
- Read and write to the same address in the same cycle: read_data shows the old word until the edge, then the new word.
- Reset (reset = 0): all memory words clear to 0 immediately and asynchronously, and writes are blocked.
  - Outputs during reset: read_data = 0 when memread = 1, or when reading any address.
  - alu_result, zero, alu_ctrl and jump_reg stay purely combinational; reset does not affect them.
- Reset asserted mid-operation aborts any pending write.
- Latency: every output except memory contents is combinational (0 cycles). A written word is visible one edge later.

Optional Feature:
Macro ALU_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit). It is set to signed two's-complement overflow for ADD and SUB, and is 0 for all other operations.
- Not defined: no port and no overflow logic.
- All other behaviour is identical in both cases.

Decomposition:
- Shared package mips_pkg holds: the ALU op code localparams (ALU_AND … ALU_NOR), the funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLL, FN_SRL, FN_JR), and the aluop encodings.
- Sub-modules: the ALU control decoder and the ALU are small enough to stay inline. The one natural sub-module is the data memory: mips_dmem (clk, reset, addr, wdata, we, re, rdata).

Test Plan:
1. aluop=10, funct=100000, op_a=5, op_b=7 -> alu_ctrl=0010, alu_result=12, zero=0, jump_reg=0.
2. aluop=01, op_a=op_b=32'h1234 -> alu_ctrl=0110, alu_result=0, zero=1. Then funct=101010 (aluop=10) with op_a=32'hFFFFFFFF (-1), op_b=1 -> alu_result=1.
3. aluop=10, funct=000000, shamt=4, op_b=32'h0000000F -> alu_result=32'h000000F0. Then funct=000010, shamt=4, op_b=32'h80000000 -> alu_result=32'h08000000.
4. aluop=10, funct=001000 -> jump_reg=1, alu_ctrl=0010. Then funct=111111 -> jump_reg=0, alu_ctrl=0010.
5. aluop=00, op_a=0, op_b=8, store_data=32'hDEADBEEF, memwrite=1 for one edge, then memread=1 -> read_data=32'hDEADBEEF. Address 8+DMEM_DEPTH*4 reads the same word. memread=0 -> read_data=0.
6. Write 32'hA5A5A5A5 to address 4, pulse reset low between edges -> read at address 4 returns 0. A write attempted while reset is low leaves the word at 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS execute/memory slice: ALU op codes, R-type funct values, aluop encodings.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

endpackage

// File: rtl/mips_dmem.sv
// Word-organised data memory: synchronous write, combinational read, async active-low clear.
module mips_dmem #(
  parameter int DATA_W     = 32,
  parameter int DMEM_DEPTH = 256,
  parameter int DMEM_AW    = $clog2(DMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DMEM_AW-1:0] addr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               we,
  input  logic               re,
  output logic [DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem_q [DMEM_DEPTH];

  // Whole array clears on reset so nothing stale survives an aborted sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DMEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = (re && reset) ? mem_q[addr] : '0;

endmodule

// File: rtl/mips_exec_mem_unit.sv
// Execute + memory slice: ALU-control decode, 32-bit ALU, data memory.
// Optional macro ALU_OVERFLOW_EN adds a signed-overflow output for ADD/SUB.
module mips_exec_mem_unit
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DMEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] store_data,
  input  logic              memread,
  input  logic              memwrite,
  output logic [3:0]        alu_ctrl,
  output logic              jump_reg,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
`ifdef ALU_OVERFLOW_EN
  output logic              overflow,
`endif
  output logic [DATA_W-1:0] read_data
);

  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  always_comb begin
    alu_ctrl = ALU_ADD;
    jump_reg = 1'b0;
    case (aluop)
      ALUOP_MEM: alu_ctrl = ALU_ADD;
      ALUOP_BEQ: alu_ctrl = ALU_SUB;
      ALUOP_ORI: alu_ctrl = ALU_OR;
      default: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_NOR:  alu_ctrl = ALU_NOR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          FN_SLL:  alu_ctrl = ALU_SLL;
          FN_SRL:  alu_ctrl = ALU_SRL;
          FN_JR: begin
            alu_ctrl = ALU_ADD;
            jump_reg = 1'b1;
          end
          default: alu_ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    alu_result = sum;
    case (alu_ctrl)
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_ADD: alu_result = sum;
      ALU_SLL: alu_result = op_b << shamt;
      ALU_SRL: alu_result = op_b >> shamt;
      ALU_SUB: alu_result = diff;
      ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_NOR: alu_result = ~(op_a | op_b);
      default: alu_result = sum;
    endcase
  end

  assign zero = (alu_result == '0);

`ifdef ALU_OVERFLOW_EN
  always_comb begin
    overflow = 1'b0;
    if (alu_ctrl == ALU_ADD)
      overflow = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
    else if (alu_ctrl == ALU_SUB)
      overflow = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);
  end
`endif

  // Byte address -> word index; low two bits and high bits dropped, so addresses wrap.
  mips_dmem #(
    .DATA_W    (DATA_W),
    .DMEM_DEPTH(DMEM_DEPTH),
    .DMEM_AW   (DMEM_AW)
  ) u_dmem (
    .clk  (clk),
    .reset(reset),
    .addr (alu_result[DMEM_AW+1:2]),
    .wdata(store_data),
    .we   (memwrite),
    .re   (memread),
    .rdata(read_data)
  );

endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// Scoreboard bench for mips_exec_mem_unit: expectations queued at drive time, drained after settle.
module tb_mips_exec_mem_unit;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] op_a, op_b, store_data;
  logic        memread, memwrite;
  logic [3:0]  alu_ctrl;
  logic        jump_reg;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] read_data;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  always #5 clk = ~clk;

  mips_exec_mem_unit #(.DATA_W(32), .DMEM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .aluop     (aluop),
    .funct     (funct),
    .shamt     (shamt),
    .op_a      (op_a),
    .op_b      (op_b),
    .store_data(store_data),
    .memread   (memread),
    .memwrite  (memwrite),
    .alu_ctrl  (alu_ctrl),
    .jump_reg  (jump_reg),
    .alu_result(alu_result),
    .zero      (zero),
`ifdef ALU_OVERFLOW_EN
    .overflow  (overflow),
`endif
    .read_data (read_data)
  );

  localparam int S_CTRL = 0, S_JR = 1, S_RES = 2, S_ZERO = 3, S_RD = 4, S_OVF = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mdl [DEPTH];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      S_CTRL:  return {28'd0, alu_ctrl};
      S_JR:    return {31'd0, jump_reg};
      S_RES:   return alu_result;
      S_ZERO:  return {31'd0, zero};
`ifdef ALU_OVERFLOW_EN
      S_OVF:   return {31'd0, overflow};
`endif
      default: return read_data;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, sample(e.sel), e.exp);
    end
  endtask

  task automatic set_alu(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
    aluop = op; funct = fn; shamt = sh; op_a = a; op_b = b;
  endtask

  // Independent reference for R-type results.
  function automatic logic [31:0] ref_rtype(input logic [5:0] fn, input logic [4:0] sh,
                                            input logic [31:0] a, input logic [31:0] b);
    case (fn)
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100111: return ~(a | b);
      6'b101010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'b000000: return b << sh;
      6'b000010: return b >> sh;
      default:   return a + b;
    endcase
  endfunction

  function automatic logic [3:0] ref_ctrl(input logic [5:0] fn);
    case (fn)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      6'b000000: return 4'b0011;
      6'b000010: return 4'b0100;
      default:   return 4'b0010;
    endcase
  endfunction

  task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    set_alu(2'b00, 6'd0, 5'd0, 32'd0, addr);
    store_data = data;
    memwrite = 1'b1;
    @(posedge clk);
    #1 memwrite = 1'b0;
  endtask

  initial begin
    logic [5:0]  fns [9];
    logic [31:0] a, b, d;
    logic [5:0]  fn;
    logic [4:0]  sh;
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
            6'b101010, 6'b000000, 6'b000010, 6'b001000};

    reset = 1'b0; memread = 1'b1; memwrite = 1'b0; store_data = 32'd0;
    set_alu(2'b00, 6'd0, 5'd0, 32'd0, 32'd20);
    expect_val("rst_read_20", S_RD, 32'd0);
    expect_val("rst_alu_comb", S_RES, 32'd20);
    drain();
    op_b = 32'd1020;
    expect_val("rst_read_1020", S_RD, 32'd0);
    drain();
    @(negedge clk) reset = 1'b1;

    // 1: R-type add
    set_alu(2'b10, 6'b100000, 5'd0, 32'd5, 32'd7);
    expect_val("t1_ctrl", S_CTRL, 32'h2);
    expect_val("t1_res", S_RES, 32'd12);
    expect_val("t1_zero", S_ZERO, 32'd0);
    expect_val("t1_jr", S_JR, 32'd0);
    drain();

    // 2: beq subtract, then signed slt
    set_alu(2'b01, 6'b000000, 5'd0, 32'h1234, 32'h1234);
    expect_val("t2_ctrl", S_CTRL, 32'h6);
    expect_val("t2_res", S_RES, 32'd0);
    expect_val("t2_zero", S_ZERO, 32'd1);
    drain();
    set_alu(2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1);
    expect_val("t2_slt", S_RES, 32'd1);
    expect_val("t2_slt_ctrl", S_CTRL, 32'h7);
    drain();

    // 3: shifts
    set_alu(2'b10, 6'b000000, 5'd4, 32'hFFFF_FFFF, 32'h0000_000F);
    expect_val("t3_sll", S_RES, 32'h0000_00F0);
    drain();
    set_alu(2'b10, 6'b000010, 5'd4, 32'hFFFF_FFFF, 32'h8000_0000);
    expect_val("t3_srl", S_RES, 32'h0800_0000);
    drain();

    // 4: jr and unknown funct
    set_alu(2'b10, 6'b001000, 5'd0, 32'd100, 32'd0);
    expect_val("t4_jr", S_JR, 32'd1);
    expect_val("t4_jr_ctrl", S_CTRL, 32'h2);
    drain();
    funct = 6'b111111;
    expect_val("t4_unk_jr", S_JR, 32'd0);
    expect_val("t4_unk_ctrl", S_CTRL, 32'h2);
    drain();
    aluop = 2'b00; funct = 6'b001000;
    expect_val("t4_jr_needs_rtype", S_JR, 32'd0);
    drain();
    set_alu(2'b11, 6'b100010, 5'd0, 32'hF0F0_0000, 32'h0000_0F0F);
    expect_val("ori_ctrl", S_CTRL, 32'h1);
    expect_val("ori_res", S_RES, 32'hF0F0_0F0F);
    drain();

    // 5: store/load, same-cycle old word, wrap, memread gating
    @(negedge clk);
    set_alu(2'b00, 6'd0, 5'd0, 32'd0, 32'd8);
    store_data = 32'hDEAD_BEEF; memwrite = 1'b1; memread = 1'b1;
    expect_val("t5_old_word", S_RD, 32'd0);
    drain();
    @(posedge clk);
    #1 memwrite = 1'b0;
    expect_val("t5_read", S_RD, 32'hDEAD_BEEF);
    drain();
    op_b = 32'd8 + DEPTH * 4;
    expect_val("t5_wrap", S_RD, 32'hDEAD_BEEF);
    drain();
    op_b = 32'd11;
    expect_val("t5_lowbits", S_RD, 32'hDEAD_BEEF);
    drain();
    memread = 1'b0;
    expect_val("t5_noread", S_RD, 32'd0);
    drain();

    // 6: reset clears, write blocked under reset
    memread = 1'b1;
    mem_write(32'd4, 32'hA5A5_A5A5);
    expect_val("t6_written", S_RD, 32'hA5A5_A5A5);
    drain();
    @(negedge clk);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    expect_val("t6_cleared", S_RD, 32'd0);
    op_b = 32'd8;
    expect_val("t6_cleared_8", S_RD, 32'd0);
    drain();
    @(negedge clk);
    set_alu(2'b00, 6'd0, 5'd0, 32'd0, 32'd4);
    store_data = 32'h1357_9BDF; memwrite = 1'b1; reset = 1'b0;
    @(posedge clk);
    #1 memwrite = 1'b0; reset = 1'b1;
    expect_val("t6_blocked", S_RD, 32'd0);
    drain();

`ifdef ALU_OVERFLOW_EN
    set_alu(2'b10, 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'd1);
    expect_val("ovf_add", S_OVF, 32'd1);
    drain();
    set_alu(2'b01, 6'd0, 5'd0, 32'h8000_0000, 32'd1);
    expect_val("ovf_sub", S_OVF, 32'd1);
    drain();
    set_alu(2'b10, 6'b100100, 5'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    expect_val("ovf_and", S_OVF, 32'd0);
    drain();
`endif

    // Random R-type sweep against the reference model
    for (int i = 0; i < 24; i++) begin
      fn = fns[$urandom_range(0, 8)];
      sh = 5'($urandom);
      a  = $urandom;
      b  = (i % 4 == 0) ? a : $urandom;
      set_alu(2'b10, fn, sh, a, b);
      expect_val($sformatf("rnd_res_%0d", i), S_RES, ref_rtype(fn, sh, a, b));
      expect_val($sformatf("rnd_ctrl_%0d", i), S_CTRL, {28'd0, ref_ctrl(fn)});
      expect_val($sformatf("rnd_zero_%0d", i), S_ZERO, {31'd0, ref_rtype(fn, sh, a, b) == 32'd0});
      drain();
    end

    // Random memory traffic against a shadow array (memory is all-zero here)
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
    mdl[1] = 32'd0;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      d = $urandom;
      mem_write(a, d);
      mdl[a[9:2]] = d;
    end
    for (int i = 0; i < 20; i++) begin
      b = (i % 2 == 0) ? $urandom : {$urandom_range(0, 3), 8'($urandom_range(0, 15)), 2'b00};
      set_alu(2'b00, 6'd0, 5'd0, 32'd0, b);
      expect_val($sformatf("mem_rd_%0d", i), S_RD, mdl[b[9:2]]);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
